// File: rtl/cim_seq_ctrl.sv
// CIM array sequencer: SET -> COMP -> INBIT -> WAIT -> READ(ROWS rows) -> DONE, started by a cal_b rising edge.
// Optional macro CIM_MULTIBIT_INPUT_EN repeats COMP/INBIT/WAIT for 4 input bits before readout.
module cim_seq_ctrl #(
    parameter int ROWS   = 16,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_b,
    input  logic              epol,
    input  logic              eact,
    input  logic [WAIT_W-1:0] wait_cyc,
    output logic              set_o,
    output logic              comp_o,
    output logic              inbit_o,
    output logic [1:0]        inbit_idx,
    output logic              read,
    output logic [3:0]        cim_a,
    output logic              pol_o,
    output logic              act_o,
    output logic              busy,
    output logic              done
);

`ifdef CIM_MULTIBIT_INPUT_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_COMP, S_INBIT, S_WAIT, S_READ, S_DONE
    } state_t;

    state_t            state, state_d;
    logic              cal_q, armed, go;
    logic [WAIT_W-1:0] wlen, wlast, wcnt, wcnt_d;
    logic [3:0]        row, row_d;
    logic [1:0]        idx, idx_d;

    // armed stays low after reset until cal_b is seen low, so a level held
    // through reset cannot masquerade as a fresh rising edge.
    assign go    = (state == S_IDLE) && cal_b && !cal_q && armed;
    assign wlast = (wlen == '0) ? '0 : wlen - WAIT_W'(1);

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        row_d   = row;
        idx_d   = idx;
        case (state)
            S_IDLE:  if (go) state_d = S_SET;
            S_SET:   state_d = S_COMP;
            S_COMP:  state_d = S_INBIT;
            S_INBIT: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt >= wlast) begin
                    if (MULTI && idx != 2'd3) begin
                        state_d = S_COMP;
                        idx_d   = idx + 2'd1;
                    end else begin
                        state_d = S_READ;
                        row_d   = '0;
                    end
                end else begin
                    wcnt_d = wcnt + WAIT_W'(1);
                end
            end
            S_READ: begin
                if (row == LAST_ROW) state_d = S_DONE;
                else                 row_d   = row + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort: DONE is exempt so a completed run still returns cleanly.
        if (!cal_b && state != S_IDLE && state != S_DONE) state_d = S_IDLE;
        if (state_d == S_IDLE) idx_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cal_q <= 1'b0;
            armed <= 1'b0;
            wlen  <= '0;
            wcnt  <= '0;
            row   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cal_q <= cal_b;
            armed <= armed | ~cal_b;
            wcnt  <= wcnt_d;
            row   <= row_d;
            idx   <= idx_d;
            if (go) wlen <= wait_cyc;
        end
    end

    // Outputs are decoded from the next state so each strobe lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_o     <= 1'b0;
            comp_o    <= 1'b0;
            inbit_o   <= 1'b0;
            inbit_idx <= '0;
            read      <= 1'b0;
            cim_a     <= '0;
            pol_o     <= 1'b0;
            act_o     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            set_o     <= (state_d == S_SET);
            comp_o    <= (state_d == S_COMP);
            inbit_o   <= (state_d == S_INBIT);
            inbit_idx <= idx_d;
            read      <= (state_d == S_READ);
            cim_a     <= (state_d == S_READ) ? row_d : 4'd0;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            if (go) begin
                pol_o <= epol;
                act_o <= eact;
            end
        end
    end

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Directed bench for cim_seq_ctrl: timeline vector tables plus abort and async-reset sequences.
module tb_cim_seq_ctrl;

`ifdef CIM_MULTIBIT_INPUT_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif
    localparam int ROWS = 16;

    logic       clk, rst, cal_b, epol, eact;
    logic [3:0] wait_cyc;
    logic       set_o, comp_o, inbit_o, read, pol_o, act_o, busy, done;
    logic [1:0] inbit_idx;
    logic [3:0] cim_a;
    logic [13:0] obs;

    int ncmp = 0;
    int nerr = 0;

    cim_seq_ctrl #(.ROWS(ROWS), .WAIT_W(4)) dut (
        .clk(clk), .rst(rst), .cal_b(cal_b), .epol(epol), .eact(eact),
        .wait_cyc(wait_cyc), .set_o(set_o), .comp_o(comp_o), .inbit_o(inbit_o),
        .inbit_idx(inbit_idx), .read(read), .cim_a(cim_a), .pol_o(pol_o),
        .act_o(act_o), .busy(busy), .done(done)
    );

    // {set, comp, inbit, idx[1:0], read, cim_a[3:0], pol, act, busy, done}
    assign obs = {set_o, comp_o, inbit_o, inbit_idx, read, cim_a, pol_o, act_o, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cal;
        logic        ep;
        logic        ea;
        logic [3:0]  wc;
        logic [13:0] exp;
        int          k;
        string       nm;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    // Expected outputs after edge k of a run started at edge 1 (cal_b high from k=1).
    // p0/a0: held pol/act before the run; p1/a1: values captured at start.
    function automatic logic [13:0] exp_out(input int k, input int w,
                                            input logic p0, input logic a0,
                                            input logic p1, input logic a1);
        int nl, we, per, rs, j, r;
        logic s, c, ib, rd, bs, dn;
        logic [1:0] ix;
        logic [3:0] ca;
        s = 0; c = 0; ib = 0; rd = 0; dn = 0; ix = 0; ca = 0;
        nl  = MULTI ? 4 : 1;
        we  = (w == 0) ? 1 : w;
        per = 2 + we;
        rs  = 2 + nl * per;
        if (k == 1) s = 1;
        else if (k >= 2 && k < rs) begin
            j  = (k - 2) / per;
            r  = (k - 2) % per;
            c  = (r == 0);
            ib = (r == 1);
            ix = MULTI ? 2'(j) : 2'd0;
        end else if (k >= rs && k < rs + ROWS) begin
            rd = 1;
            ca = 4'(k - rs);
            ix = MULTI ? 2'd3 : 2'd0;
        end else if (k == rs + ROWS) begin
            dn = 1;
            ix = MULTI ? 2'd3 : 2'd0;
        end
        bs = (k >= 1) && (k <= rs + ROWS);
        return {s, c, ib, ix, rd, ca, (k >= 1) ? p1 : p0, (k >= 1) ? a1 : a0, bs, dn};
    endfunction

    function automatic vec_t mk(input string nm, input int k, input logic cal,
                                input logic ep, input logic ea, input logic [3:0] wc,
                                input logic [13:0] exp);
        vec_t v;
        v.nm = nm; v.k = k; v.cal = cal; v.ep = ep; v.ea = ea; v.wc = wc; v.exp = exp;
        return v;
    endfunction

    initial begin
        int nrun;
        bit hit;

        // Run A: wait_cyc=2, cal_b rises and stays high through and past DONE.
        nrun = 2 + (MULTI ? 4 : 1) * 4 + ROWS + 4;
        for (int k = 0; k < nrun; k++)
            tv.push_back(mk("runA", k, k >= 1, 1'b0, 1'b1, 4'd2, exp_out(k, 2, 1'b0, 1'b0, 1'b0, 1'b1)));
        // Run B: wait_cyc=0, epol=1, eact=0 captured; inputs change afterwards.
        nrun = 2 + (MULTI ? 4 : 1) * 3 + ROWS + 3;
        for (int k = 0; k < nrun; k++) begin
            if (k == 1)
                tv.push_back(mk("runB", k, 1'b1, 1'b1, 1'b0, 4'd0, exp_out(k, 0, 1'b0, 1'b1, 1'b1, 1'b0)));
            else
                tv.push_back(mk("runB", k, k >= 1, 1'b0, 1'b1, 4'd7, exp_out(k, 0, 1'b0, 1'b1, 1'b1, 1'b0)));
        end

        rst = 1'b1; cal_b = 1'b0; epol = 1'b0; eact = 1'b0; wait_cyc = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", obs, 14'd0);
        rst = 1'b0;

        foreach (tv[i]) begin
            cal_b = tv[i].cal; epol = tv[i].ep; eact = tv[i].ea; wait_cyc = tv[i].wc;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_k%0d", tv[i].nm, tv[i].k), obs, tv[i].exp);
        end

        // Abort during READ at the 8th row: back to IDLE, no done pulse.
        cal_b = 1'b0;
        @(negedge clk);
        cal_b = 1'b1; epol = 1'b1; eact = 1'b1; wait_cyc = 4'd2;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (read && cim_a == 4'd7) hit = 1;
        end
        chk("abort_reach_row7", hit, 1);
        cal_b = 1'b0;
        @(negedge clk);
        chk("abort_idle", obs, {10'b0, 4'b1100});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {busy, done, read}, 3'b000);
        end

        // Async reset mid-WAIT, then cal_b held high must not restart.
        @(negedge clk);
        cal_b = 1'b1; epol = 1'b0; eact = 1'b0; wait_cyc = 4'd3;
        repeat (4) @(negedge clk);
        chk("pre_rst_wait", obs, {10'b0, 4'b0010});
        #2 rst = 1'b1;
        #1 chk("rst_async", obs, 14'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_restart", {busy, set_o}, 2'b00);
        end
        cal_b = 1'b0;
        @(negedge clk);
        cal_b = 1'b1;
        @(negedge clk);
        chk("restart_after_low", obs, {1'b1, 9'b0, 4'b0010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
